// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory_block among NREQ requesters.
// Read data returns through a credit-protected response FIFO, tagged with requester ID.
module mem_port_arbiter #(
   parameter int NREQ      = 4,
   parameter int DATAW     = 512,
   parameter int DEPTH     = 512,
   parameter int ADDRW     = $clog2(DEPTH),
   parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1,
   parameter int RD_LAT    = 2,
   // RSP_DEPTH must be >= RD_LAT so a full pipeline always has FIFO room
   parameter int RSP_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_wr,
   input  logic [NREQ*ADDRW-1:0]  req_addr,
   input  logic [NREQ*DATAW-1:0]  req_wdata,
   output logic [NREQ-1:0]        req_ready,
   output logic                   mem_wen,
   output logic [ADDRW-1:0]       mem_waddr,
   output logic [DATAW-1:0]       mem_wdata,
   output logic [ADDRW-1:0]       mem_raddr,
   input  logic [DATAW-1:0]       mem_rdata,
   output logic                   rsp_valid,
   output logic [IDW-1:0]         rsp_id,
   output logic [DATAW-1:0]       rsp_data,
   input  logic                   rsp_ready
);

   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

   logic [IDW-1:0]   rr_ptr;
   logic [CW-1:0]    credits;
   logic [NREQ-1:0]  eligible;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   grant_id;
   logic             grant_any;
   logic             grant_wr;
   logic             rd_grant;
   logic [ADDRW-1:0] sel_addr;
   logic [DATAW-1:0] sel_wdata;

   logic             pipe_vld [RD_LAT];
   logic [IDW-1:0]   pipe_id  [RD_LAT];

   logic [IDW-1:0]   fifo_id   [RSP_DEPTH];
   logic [DATAW-1:0] fifo_data [RSP_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NREQ) sum = sum - NREQ;
      return IDW'(sum);
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Reads need a credit so every granted read is guaranteed a FIFO slot.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         eligible[i] = req_valid[i] & (req_wr[i] | (credits != '0));
      end
   end

   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = '0;
      if (!rst) begin
         for (int k = 0; k < NREQ; k++) begin
            cand = wrap_idx(rr_ptr, k);
            if (!grant_any && eligible[cand]) begin
               grant_any = 1'b1;
               grant_id  = cand;
            end
         end
      end
   end

   assign req_ready = grant_any ? (NREQ'(1) << grant_id) : '0;
   assign grant_wr  = grant_any & req_wr[grant_id];
   assign rd_grant  = grant_any & ~req_wr[grant_id];
   assign sel_addr  = req_addr[int'(grant_id)*ADDRW +: ADDRW];
   assign sel_wdata = req_wdata[int'(grant_id)*DATAW +: DATAW];

   assign mem_wen   = grant_wr;
   assign mem_waddr = grant_wr ? sel_addr : '0;
   assign mem_wdata = grant_wr ? sel_wdata : '0;
   assign mem_raddr = rd_grant ? sel_addr : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (grant_any) begin
         rr_ptr <= wrap_idx(grant_id, 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CW'(RSP_DEPTH);
      end else if (rd_grant && !pop) begin
         credits <= credits - 1'b1;
      end else if (!rd_grant && pop) begin
         credits <= credits + 1'b1;
      end
   end

   // ID pipeline mirrors the memory read latency so the tag lines up with mem_rdata.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_vld[i] <= 1'b0;
            pipe_id[i]  <= '0;
         end
      end else begin
         pipe_vld[0] <= rd_grant;
         pipe_id[0]  <= rd_grant ? grant_id : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_id[i]  <= pipe_id[i-1];
         end
      end
   end

   assign push      = pipe_vld[RD_LAT-1];
   assign rsp_valid = (count != '0);
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_id    = fifo_id[rd_ptr];
   assign rsp_data  = fifo_data[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_id[wr_ptr]   <= pipe_id[RD_LAT-1];
         fifo_data[wr_ptr] <= mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural two-cycle memory_block.
// Directed cycles carry hand-derived grants; a monitor checks responses in grant order.
module tb_mem_port_arbiter;

   localparam int NREQ      = 4;
   localparam int DATAW     = 512;
   localparam int DEPTH     = 512;
   localparam int ADDRW     = 9;
   localparam int IDW       = 2;
   localparam int RD_LAT    = 2;
   localparam int RSP_DEPTH = 4;

   typedef struct packed {
      logic [IDW-1:0]   id;
      logic [DATAW-1:0] data;
   } rsp_t;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_wr;
   logic [NREQ*ADDRW-1:0] req_addr;
   logic [NREQ*DATAW-1:0] req_wdata;
   logic [NREQ-1:0]       req_ready;
   logic                  mem_wen;
   logic [ADDRW-1:0]      mem_waddr;
   logic [DATAW-1:0]      mem_wdata;
   logic [ADDRW-1:0]      mem_raddr;
   logic [DATAW-1:0]      mem_rdata;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [DATAW-1:0]      rsp_data;
   logic                  rsp_ready;
   logic                  preload_en;

   logic [DATAW-1:0]      mem_array [DEPTH];
   logic [ADDRW-1:0]      mem_raddr_q;

   logic [ADDRW-1:0]      stage_addr [NREQ];
   logic [DATAW-1:0]      stage_data [NREQ];
   logic [DATAW-1:0]      stage_exp  [NREQ];

   rsp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_port_arbiter #(
      .NREQ(NREQ), .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .IDW(IDW),
      .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DATAW-1:0] init_val(input int a);
      logic [31:0] w;
      if (a == 5) return DATAW'(32'hAB);
      if (a == 9) return DATAW'(32'h11);
      w = 32'hD000_0000 + 32'(a);
      return {(DATAW/32){w}};
   endfunction

   // Address register then output register: data appears two cycles after raddr.
   always @(posedge clk) begin
      if (preload_en) begin
         for (int a = 0; a < DEPTH; a++) mem_array[a] <= init_val(a);
      end else if (mem_wen) begin
         mem_array[mem_waddr] <= mem_wdata;
      end
      mem_raddr_q <= mem_raddr;
      mem_rdata   <= mem_array[mem_raddr_q];
   end

   task automatic check_output(input string name, input logic [DATAW-1:0] act,
                               input logic [DATAW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w,
                                 input logic rr, input logic [NREQ-1:0] exp_ready,
                                 input string name);
      rsp_t e;
      @(negedge clk);
      req_valid = v;
      req_wr    = w;
      rsp_ready = rr;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*ADDRW +: ADDRW]  = stage_addr[i];
         req_wdata[i*DATAW +: DATAW] = stage_data[i];
         if (exp_ready[i] && !w[i]) begin
            e.id   = IDW'(i);
            e.data = stage_exp[i];
            sb.push_back(e);
         end
      end
      #1;
      check_output(name, DATAW'(req_ready), DATAW'(exp_ready));
   endtask

   task automatic idle(input int n, input logic rr, input string name);
      repeat (n) apply_stimulus('0, '0, rr, '0, name);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '1;
      req_wr    = '0;
      rsp_ready = 1'b0;
      sb.delete();
      #1;
      check_output("rst_req_ready", DATAW'(req_ready), '0);
      check_output("rst_mem_wen", DATAW'(mem_wen), '0);
      check_output("rst_mem_raddr", DATAW'(mem_raddr), '0);
      check_output("rst_mem_waddr", DATAW'(mem_waddr), '0);
      check_output("rst_mem_wdata", mem_wdata, '0);
      repeat (n - 1) @(negedge clk);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
      #1;
      check_output("rst_rsp_valid", DATAW'(rsp_valid), '0);
   endtask

   // Monitor: compare every popped response against the scoreboard head.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected_rsp: got id=%0d data=%0h, required no response",
                        rsp_id, rsp_data);
            end else begin
               e = sb.pop_front();
               check_output("rsp_id", DATAW'(rsp_id), DATAW'(e.id));
               check_output("rsp_data", rsp_data, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      n_checks++;
      n_fail++;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int rounds [NREQ];
      rst        = 1'b1;
      preload_en = 1'b1;
      req_valid  = '0;
      req_wr     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         stage_addr[i] = '0;
         stage_data[i] = '0;
         stage_exp[i]  = '0;
         rounds[i]     = 0;
      end
      do_reset(3);
      preload_en = 1'b0;

      // Single read: response visible RD_LAT+1 cycles after the grant.
      stage_addr[0] = ADDRW'(5);
      stage_exp[0]  = DATAW'(32'hAB);
      apply_stimulus(4'b0001, 4'b0000, 1'b1, 4'b0001, "t1_grant");
      check_output("t1_mem_raddr", DATAW'(mem_raddr), DATAW'(5));
      check_output("t1_mem_wen", DATAW'(mem_wen), '0);
      idle(1, 1'b1, "t1_idle");
      check_output("t1_lat1_valid", DATAW'(rsp_valid), '0);
      idle(1, 1'b1, "t1_idle");
      check_output("t1_lat2_valid", DATAW'(rsp_valid), '0);
      idle(1, 1'b1, "t1_idle");
      check_output("t1_lat3_valid", DATAW'(rsp_valid), DATAW'(1));
      check_output("t1_lat3_id", DATAW'(rsp_id), '0);

      // Write then read of the same address returns the new data.
      stage_addr[1] = ADDRW'(9);
      stage_data[1] = DATAW'(32'h77);
      apply_stimulus(4'b0010, 4'b0010, 1'b1, 4'b0010, "t2_wr_grant");
      check_output("t2_mem_wen", DATAW'(mem_wen), DATAW'(1));
      check_output("t2_mem_waddr", DATAW'(mem_waddr), DATAW'(9));
      check_output("t2_mem_wdata", mem_wdata, DATAW'(32'h77));
      stage_exp[1] = DATAW'(32'h77);
      apply_stimulus(4'b0010, 4'b0000, 1'b1, 4'b0010, "t2_rd_grant");
      check_output("t2_rd_mem_wen", DATAW'(mem_wen), '0);
      check_output("t2_rd_mem_raddr", DATAW'(mem_raddr), DATAW'(9));
      idle(4, 1'b1, "t2_idle");

      // Fairness: four persistent readers get grants 0,1,2,3,0,1,2,3.
      do_reset(1);
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            stage_addr[i] = ADDRW'(16 + 4*rounds[i] + i);
            stage_exp[i]  = init_val(16 + 4*rounds[i] + i);
         end
         apply_stimulus(4'b1111, 4'b0000, 1'b1, NREQ'(1) << (c % NREQ),
                        $sformatf("t3_grant%0d", c));
         rounds[c % NREQ]++;
      end
      idle(5, 1'b1, "t3_drain");

      // Backpressure: exactly RSP_DEPTH reads, then only writes pass.
      for (int c = 0; c < 4; c++) begin
         stage_addr[2] = ADDRW'(32 + c);
         stage_exp[2]  = init_val(32 + c);
         apply_stimulus(4'b0100, 4'b0000, 1'b0, 4'b0100, $sformatf("t4_rd%0d", c));
      end
      stage_addr[2] = ADDRW'(36);
      stage_exp[2]  = init_val(36);
      apply_stimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, "t4_rd_blocked");
      check_output("t4_rsp_valid", DATAW'(rsp_valid), DATAW'(1));
      stage_addr[3] = ADDRW'(100);
      stage_data[3] = DATAW'(32'h3AA);
      apply_stimulus(4'b1100, 4'b1000, 1'b0, 4'b1000, "t4_wr_pass");
      stage_addr[3] = ADDRW'(101);
      stage_data[3] = DATAW'(32'h3BB);
      // Pop while credits are zero: the read still waits this cycle.
      apply_stimulus(4'b1100, 4'b1000, 1'b1, 4'b1000, "t5_pop_no_read");
      check_output("t5_mem_wen", DATAW'(mem_wen), DATAW'(1));
      apply_stimulus(4'b0100, 4'b0000, 1'b1, 4'b0100, "t5_read_resumes");
      stage_addr[2] = ADDRW'(37);
      stage_exp[2]  = init_val(37);
      apply_stimulus(4'b0100, 4'b0000, 1'b1, 4'b0100, "t4_rd_stream");
      stage_addr[0] = ADDRW'(101);
      stage_exp[0]  = DATAW'(32'h3BB);
      apply_stimulus(4'b0001, 4'b0000, 1'b1, 4'b0001, "t4_readback101");
      stage_addr[0] = ADDRW'(100);
      stage_exp[0]  = DATAW'(32'h3AA);
      apply_stimulus(4'b0001, 4'b0000, 1'b1, 4'b0001, "t4_readback100");
      idle(6, 1'b1, "t4_drain");

      // Reset with reads in flight drops them and restores pointer and credits.
      for (int c = 0; c < 3; c++) begin
         stage_addr[1] = ADDRW'(40 + c);
         stage_exp[1]  = init_val(40 + c);
         apply_stimulus(4'b0010, 4'b0000, 1'b0, 4'b0010, $sformatf("t6_inflight%0d", c));
      end
      do_reset(1);
      for (int i = 0; i < NREQ; i++) begin
         stage_addr[i] = ADDRW'(48 + i);
         stage_exp[i]  = init_val(48 + i);
      end
      apply_stimulus(4'b1111, 4'b0000, 1'b0, 4'b0001, "t6_grant0");
      apply_stimulus(4'b1110, 4'b0000, 1'b0, 4'b0010, "t6_grant1");
      apply_stimulus(4'b1100, 4'b0000, 1'b0, 4'b0100, "t6_grant2");
      apply_stimulus(4'b1000, 4'b0000, 1'b0, 4'b1000, "t6_grant3");
      stage_addr[0] = ADDRW'(60);
      apply_stimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, "t6_credits_out");
      idle(8, 1'b1, "t6_drain");
      check_output("t6_rsp_valid_end", DATAW'(rsp_valid), '0);
      check_output("sb_empty", DATAW'(sb.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
